dispatch: RTL and testbench

- Block-level work distributor for the GPU top level. Sits between the device-control start/thread_count registers and the NUM_CORES compute cores.
- On a kernel launch it splits thread_count into blocks of THREADS_PER_BLOCK threads and hands one block at a time to each idle core.
- It recycles cores as they finish and asserts done once every block has completed.

---
 rtl/dispatch_pkg.sv | 12 +
 rtl/dispatch_if.sv | 32 +++
 rtl/dispatch.sv | 125 ++++++++++++
 tb/tb_dispatch.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_pkg.sv
// Shared GPU dispatch definitions: id/count widths and the
// per-block thread-count width helper.
package dispatch_pkg;

    localparam int BID_W = 8;
    localparam int TC_W  = 8;

    function automatic int tcw(input int tpb);
        return $clog2(tpb) + 1;
    endfunction

endpackage

// File: rtl/dispatch_if.sv
// Launch/control and per-core block assignment signals between
// the device-control registers, the dispatcher and the cores.
interface dispatch_if
    import dispatch_pkg::*;
#(
    parameter int NUM_CORES = 2,
    parameter int TPB       = 4
);
    localparam int CW = tcw(TPB);

    logic                 start;
    logic [TC_W-1:0]      thread_count;
    logic [NUM_CORES-1:0] core_done;
    logic [NUM_CORES-1:0] core_start;
    logic [NUM_CORES-1:0] core_reset;
    logic [BID_W-1:0]     core_block_id     [NUM_CORES];
    logic [CW-1:0]        core_thread_count [NUM_CORES];
    logic                 done;

    modport slave (
        input  start, thread_count, core_done,
        output core_start, core_reset, core_block_id,
        output core_thread_count, done
    );

    modport master (
        output start, thread_count, core_done,
        input  core_start, core_reset, core_block_id,
        input  core_thread_count, done
    );

endinterface

// File: rtl/dispatch.sv
// Block-level work distributor: splits a kernel into fixed-size
// blocks, hands them to idle cores and reports kernel completion.
module dispatch
    import dispatch_pkg::*;
#(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = 4
) (
    input  logic      clk,
    input  logic      reset,
    dispatch_if.slave bus
);
    localparam int LOG2 = $clog2(THREADS_PER_BLOCK);
    localparam int CW   = tcw(THREADS_PER_BLOCK);
    localparam logic [CW-1:0]   FULL   = CW'(THREADS_PER_BLOCK);
    localparam logic [TC_W-1:0] TPB_M1 = TC_W'(THREADS_PER_BLOCK - 1);

    logic             r_running;
    logic             r_done;
    logic [BID_W-1:0] r_total;
    logic [BID_W-1:0] r_disp;
    logic [BID_W-1:0] r_bdone;
    logic [CW-1:0]    r_last;

    logic [TC_W:0]        w_sum9;
    logic [TC_W:0]        w_shift;
    logic [BID_W-1:0]     w_total;
    logic [BID_W-1:0]     w_base;
    logic [TC_W-1:0]      w_last;
    logic [NUM_CORES-1:0] w_idle;
    logic [NUM_CORES-1:0] w_busy;
    logic [NUM_CORES-1:0] w_grant;
    logic [NUM_CORES-1:0] w_fin;
    logic [BID_W-1:0]     w_id [NUM_CORES];
    logic [BID_W-1:0]     w_ndisp;
    logic [BID_W-1:0]     w_nfin;

    // 9-bit sum so thread_count=255 still rounds up correctly
    assign w_sum9  = {1'b0, bus.thread_count} + {1'b0, TPB_M1};
    assign w_shift = w_sum9 >> LOG2;
    assign w_total = w_shift[BID_W-1:0];
    assign w_base  = (w_total - BID_W'(1)) << LOG2;
    assign w_last  = bus.thread_count - w_base;

    // Idle cores take consecutive ids in ascending core order
    always_comb begin
        w_grant = '0;
        w_fin   = '0;
        w_ndisp = r_disp;
        w_nfin  = '0;
        w_id    = '{default: '0};
        for (int i = 0; i < NUM_CORES; i++) begin
            w_id[i] = w_ndisp;
            if (w_idle[i] && (w_ndisp < r_total)) begin
                w_grant[i] = 1'b1;
                w_ndisp    = w_ndisp + BID_W'(1);
            end
            if (w_busy[i] && bus.core_done[i]) begin
                w_fin[i] = 1'b1;
                w_nfin   = w_nfin + BID_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_total   <= '0;
            r_disp    <= '0;
            r_bdone   <= '0;
            r_last    <= FULL;
        end else if (!r_running) begin
            if (bus.start) begin
                r_running <= 1'b1;
                r_total   <= w_total;
                r_last    <= w_last[CW-1:0];
            end
        end else begin
            r_disp  <= w_ndisp;
            r_bdone <= r_bdone + w_nfin;
            if (r_bdone == r_total)
                r_done <= 1'b1;
        end
    end

    assign bus.done = r_done;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
        logic             r_start;
        logic             r_rst;
        logic [BID_W-1:0] r_id;
        logic [CW-1:0]    r_cnt;

        always_ff @(posedge clk) begin
            if (!reset) begin
                r_start <= 1'b0;
                r_rst   <= 1'b1;
                r_id    <= '0;
                r_cnt   <= FULL;
            end else if (r_running) begin
                if (r_rst)
                    r_rst <= 1'b0;
                if (w_grant[g]) begin
                    r_start <= 1'b1;
                    r_id    <= w_id[g];
                    r_cnt   <= (w_id[g] == r_total - BID_W'(1))
                             ? r_last : FULL;
                end
                if (w_fin[g]) begin
                    r_start <= 1'b0;
                    r_rst   <= 1'b1;
                end
            end
        end

        assign w_idle[g]                 = r_rst;
        assign w_busy[g]                 = r_start;
        assign bus.core_start[g]         = r_start;
        assign bus.core_reset[g]         = r_rst;
        assign bus.core_block_id[g]      = r_id;
        assign bus.core_thread_count[g]  = r_cnt;
    end

endmodule

// File: tb/tb_dispatch.sv
// Self-checking bench for dispatch: directed launches plus random
// kernels compared every cycle against a block-level model.
`timescale 1ns/1ps
module tb_dispatch;
    localparam int NC  = 2;
    localparam int TPB = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   cmp_en   = 1'b0;

    dispatch_if #(.NUM_CORES(NC), .TPB(TPB)) bus ();

    dispatch #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB)) u_dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // block-level model
    int m_run, m_done, m_total, m_last, m_next, m_fin, m_tc, m_sum;
    int m_start [NC];
    int m_rst   [NC];
    int m_id    [NC];
    int m_cnt   [NC];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int was [NC];
        int fin [NC];
        if (!rst_n) begin
            m_run = 0; m_done = 0; m_total = 0; m_next = 0;
            m_fin = 0; m_sum = 0; m_tc = 0; m_last = TPB;
            for (int i = 0; i < NC; i++) begin
                m_start[i] = 0; m_rst[i] = 1;
                m_id[i] = 0; m_cnt[i] = TPB;
            end
            return;
        end
        if (m_run == 0) begin
            if (bus.start) begin
                m_run   = 1;
                m_tc    = int'(bus.thread_count);
                m_total = (m_tc + TPB - 1) / TPB;
                m_last  = m_tc - (m_total - 1) * TPB;
            end
            return;
        end
        if (m_fin == m_total) m_done = 1;
        for (int i = 0; i < NC; i++) begin
            was[i] = m_rst[i];
            fin[i] = (m_start[i] != 0 && bus.core_done[i]) ? 1 : 0;
        end
        for (int i = 0; i < NC; i++) begin
            if (was[i] != 0) begin
                m_rst[i] = 0;
                if (m_next < m_total) begin
                    m_start[i] = 1;
                    m_id[i]    = m_next;
                    m_cnt[i]   = (m_next == m_total - 1) ? m_last : TPB;
                    m_sum     += m_cnt[i];
                    m_next++;
                end
            end
        end
        for (int i = 0; i < NC; i++) begin
            if (fin[i] != 0) begin
                m_start[i] = 0;
                m_rst[i]   = 1;
                m_fin++;
            end
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin : compare
        logic [NC-1:0] es, er;
        if (cmp_en) begin
            for (int i = 0; i < NC; i++) begin
                es[i] = (m_start[i] != 0);
                er[i] = (m_rst[i] != 0);
            end
            chk("done", 32'(bus.done), 32'(m_done));
            chk("core_start", 32'(bus.core_start), 32'(es));
            chk("core_reset", 32'(bus.core_reset), 32'(er));
            for (int i = 0; i < NC; i++) begin
                chk("block_id", 32'(bus.core_block_id[i]), 32'(m_id[i]));
                chk("thr_cnt", 32'(bus.core_thread_count[i]),
                    32'(m_cnt[i]));
            end
        end
    end

    task automatic hold_reset(input int n);
        rst_n            = 1'b0;
        bus.start        = 1'b0;
        bus.core_done    = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic launch(input int tc);
        rst_n            = 1'b1;
        bus.start        = 1'b1;
        bus.thread_count = 8'(tc);
        bus.core_done    = '0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int tc, cyc, rst_at;
        bit midrst;
        bus.thread_count = '0;
        hold_reset(10);
        cmp_en = 1'b1;
        chk("rst_core_reset", 32'(bus.core_reset), 32'h3);
        chk("rst_core_start", 32'(bus.core_start), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_cnt0", 32'(bus.core_thread_count[0]), 32'd4);
        chk("rst_cnt1", 32'(bus.core_thread_count[1]), 32'd4);

        // tc=4: single block on core 0
        launch(4);
        repeat (2) @(negedge clk);
        chk("t4_start", 32'(bus.core_start), 32'h1);
        chk("t4_id0", 32'(bus.core_block_id[0]), 32'd0);
        chk("t4_cnt0", 32'(bus.core_thread_count[0]), 32'd4);
        bus.core_done = 2'b01;
        @(negedge clk);
        bus.core_done = 2'b00;
        chk("t4_reset0", 32'(bus.core_reset[0]), 32'h1);
        chk("t4_notdone", 32'(bus.done), 32'h0);
        @(negedge clk);
        chk("t4_done", 32'(bus.done), 32'h1);

        // tc=6: both cores start together, second has 2 threads
        hold_reset(2);
        launch(6);
        repeat (2) @(negedge clk);
        chk("t6_start", 32'(bus.core_start), 32'h3);
        chk("t6_id1", 32'(bus.core_block_id[1]), 32'd1);
        chk("t6_cnt1", 32'(bus.core_thread_count[1]), 32'd2);
        chk("t6_model_total", 32'(m_total), 32'd2);
        bus.core_done = 2'b01;
        @(negedge clk);
        bus.core_done = 2'b00;
        @(negedge clk);
        chk("t6_half", 32'(bus.done), 32'h0);
        bus.core_done = 2'b10;
        @(negedge clk);
        bus.core_done = 2'b00;
        @(negedge clk);
        chk("t6_done", 32'(bus.done), 32'h1);

        // tc=0: nothing starts, done the edge after launch
        hold_reset(2);
        launch(0);
        repeat (2) @(negedge clk);
        chk("t0_done", 32'(bus.done), 32'h1);
        chk("t0_start", 32'(bus.core_start), 32'h0);

        // random kernels, some interrupted by reset and relaunched
        for (int k = 0; k < 40; k++) begin
            hold_reset(2);
            tc = (k == 0) ? 255 : (k == 1) ? 10 : $urandom_range(0, 40);
            launch(tc);
            midrst = ($urandom_range(0, 3) == 0);
            rst_at = $urandom_range(2, 6);
            cyc = 0;
            while (m_done == 0 && cyc < 3000) begin
                @(negedge clk);
                cyc++;
                if (midrst && cyc == rst_at) begin
                    rst_n         = 1'b0;
                    bus.core_done = '0;
                    @(negedge clk);
                    launch($urandom_range(1, 30));
                    midrst = 1'b0;
                end else begin
                    bus.thread_count = 8'($urandom);
                    bus.core_done    = NC'($urandom);
                    bus.start        = 1'($urandom);
                end
            end
            chk("kernel_timeout", 32'(m_done), 32'd1);
            chk("model_threads", 32'(m_sum), 32'(m_tc));
            chk("model_blocks", 32'(m_next), 32'(m_total));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
